// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and data access.
// Data requests win unless fetch has waited STARVE grants; a watchdog completes hung accesses.
module mem_port_arbiter #(
    parameter int unsigned STARVE  = 4,
    parameter int unsigned MAXWAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        d_stall,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GNT_I  = 3'd1,
        GNT_D  = 3'd2,
        DONE_I = 3'd3,
        DONE_D = 3'd4
    } state_t;

    localparam logic [3:0] STARVE_L  = 4'(STARVE);
    localparam logic [7:0] MAXWAIT_L = 8'(MAXWAIT);

    state_t      state_q;
    logic [3:0]  starve_cnt_q;
    logic [3:0]  starve_cnt_d;
    logic [7:0]  wait_cnt_q;
    logic        m_req_q;
    logic        m_we_q;
    logic [31:0] m_addr_q;
    logic [31:0] m_wdata_q;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;
    logic        if_ready_q;
    logic        d_ready_q;
    logic        err_q;

    logic        grant_data;
    logic        access_end;

    assign grant_data = d_req && (!if_req || (starve_cnt_q < STARVE_L));
    // A watchdog expiry coinciding with m_ack is treated as a normal completion.
    assign access_end = m_ack || (wait_cnt_q == MAXWAIT_L);

    always_comb begin
        starve_cnt_d = 4'd0;
        if (if_req) begin
            starve_cnt_d = (starve_cnt_q == 4'hF) ? 4'hF : starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= 4'd0;
            wait_cnt_q   <= 8'd0;
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= 32'd0;
            m_wdata_q    <= 32'd0;
            if_rdata_q   <= 32'd0;
            d_rdata_q    <= 32'd0;
            if_ready_q   <= 1'b0;
            d_ready_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    wait_cnt_q <= 8'd0;
                    if (grant_data) begin
                        state_q      <= GNT_D;
                        m_req_q      <= 1'b1;
                        m_we_q       <= d_we;
                        m_addr_q     <= d_addr;
                        m_wdata_q    <= d_wdata;
                        starve_cnt_q <= starve_cnt_d;
                    end else if (if_req) begin
                        state_q      <= GNT_I;
                        m_req_q      <= 1'b1;
                        m_we_q       <= 1'b0;
                        m_addr_q     <= if_addr;
                        m_wdata_q    <= 32'd0;
                        starve_cnt_q <= 4'd0;
                    end
                end
                GNT_I, GNT_D: begin
                    if (access_end) begin
                        m_req_q <= 1'b0;
                        if (!m_ack) begin
                            err_q <= 1'b1;
                        end
                        if (state_q == GNT_I) begin
                            state_q    <= DONE_I;
                            if_ready_q <= 1'b1;
                            if_rdata_q <= m_ack ? m_rdata : 32'd0;
                        end else begin
                            state_q   <= DONE_D;
                            d_ready_q <= 1'b1;
                            if (!m_ack) begin
                                d_rdata_q <= 32'd0;
                            end else if (!m_we_q) begin
                                d_rdata_q <= m_rdata;
                            end
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                DONE_I, DONE_D: begin
                    // The finishing requester's still-high req is deliberately not re-arbitrated here.
                    if_ready_q <= 1'b0;
                    d_ready_q  <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign if_ready = if_ready_q;
    assign d_ready  = d_ready_q;
    assign err      = err_q;
    assign if_stall = if_req & ~if_ready_q;
    assign d_stall  = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level arbitration and memory reference model.
module tb_mem_port_arbiter;

    localparam int STARVE  = 4;
    localparam int MAXWAIT = 15;
    localparam int NRND    = 30;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_stall;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        d_stall;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        err;

    // Memory responder controls
    logic        resp_en = 1'b0;
    logic        rnd_lat = 1'b0;
    int          ack_delay = 0;
    logic        resp_ack = 1'b0;
    logic [31:0] resp_rdata = 32'd0;
    logic        man_ack = 1'b0;
    logic [31:0] man_rdata = 32'd0;
    int          resp_cnt = 0;
    int          resp_cur = 0;
    bit          resp_active = 1'b0;

    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    int checks = 0;
    int errors = 0;
    bit f_done = 1'b0;
    bit d_done = 1'b0;

    assign m_ack   = resp_ack | man_ack;
    assign m_rdata = resp_rdata | man_rdata;

    mem_port_arbiter #(.STARVE(STARVE), .MAXWAIT(MAXWAIT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
    );

    initial forever #5 clk = ~clk;

    // Unwritten memory words read back as a fixed function of their address.
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // Behavioural memory: acks after a chosen number of cycles of m_req.
    always @(negedge clk) begin
        resp_ack   = 1'b0;
        resp_rdata = 32'd0;
        if (resp_en && m_req && reset) begin
            if (!resp_active) begin
                resp_active = 1'b1;
                resp_cnt    = 0;
                resp_cur    = rnd_lat ? int'($urandom_range(0, 4)) : ack_delay;
            end
            if (resp_cnt == resp_cur) begin
                resp_ack    = 1'b1;
                resp_active = 1'b0;
                if (m_we) mem_arr[m_addr] = m_wdata;
                else resp_rdata = mem_arr.exists(m_addr) ? mem_arr[m_addr] : dflt(m_addr);
            end else begin
                resp_cnt++;
            end
        end else begin
            resp_active = 1'b0;
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({m_req, m_we, if_ready, d_ready, err, if_stall, d_stall} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=0000000", {m_req, m_we, if_ready, d_ready, err, if_stall, d_stall});
        end
        checks++;
        if ({m_addr, m_wdata, if_rdata, d_rdata} !== 128'd0) begin
            errors++;
            $display("FAIL reset_data got=%h/%h/%h/%h exp=0", m_addr, m_wdata, if_rdata, d_rdata);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_fetch();
        resp_en = 1'b1; rnd_lat = 1'b0; ack_delay = 0;
        mem_arr[32'h0040_0000] = 32'h2010_0005;
        if_addr = 32'h0040_0000; if_req = 1'b1;
        #1;
        checks++;
        if (if_stall !== 1'b1) begin errors++; $display("FAIL sf_stall_c0 got=%b exp=1", if_stall); end
        @(negedge clk);
        checks++;
        if ({m_req, m_we, m_addr} !== {1'b1, 1'b0, 32'h0040_0000}) begin
            errors++; $display("FAIL sf_grant got=%b/%b/%h exp=1/0/00400000", m_req, m_we, m_addr);
        end
        @(negedge clk);
        checks++;
        if ({m_req, if_ready, if_stall} !== 3'b010) begin
            errors++; $display("FAIL sf_done got=%b exp=010", {m_req, if_ready, if_stall});
        end
        checks++;
        if (if_rdata !== 32'h2010_0005) begin errors++; $display("FAIL sf_rdata got=%h exp=20100005", if_rdata); end
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (if_ready !== 1'b0) begin errors++; $display("FAIL sf_pulse got=%b exp=0", if_ready); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] old_rd;
        old_rd = 32'd0;
        if_req = 1'b1; if_addr = 32'h0040_0004;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h54; d_wdata = 32'd7;
        @(negedge clk);
        checks++;
        if ({m_req, m_we, m_addr, m_wdata} !== {1'b1, 1'b1, 32'h54, 32'd7}) begin
            errors++; $display("FAIL sim_dgrant got=%b/%b/%h/%h exp=1/1/54/7", m_req, m_we, m_addr, m_wdata);
        end
        @(negedge clk);
        checks++;
        if ({d_ready, if_ready, if_stall} !== 3'b101) begin
            errors++; $display("FAIL sim_ddone got=%b exp=101", {d_ready, if_ready, if_stall});
        end
        checks++;
        if (d_rdata !== old_rd) begin errors++; $display("FAIL sim_store_rdata got=%h exp=%h", d_rdata, old_rd); end
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (m_req !== 1'b0) begin errors++; $display("FAIL sim_idle got=%b exp=0", m_req); end
        @(negedge clk);
        checks++;
        if ({m_req, m_we, m_addr} !== {1'b1, 1'b0, 32'h0040_0004}) begin
            errors++; $display("FAIL sim_igrant got=%b/%b/%h exp=1/0/00400004", m_req, m_we, m_addr);
        end
        @(negedge clk);
        checks++;
        if ({if_ready, if_rdata} !== {1'b1, dflt(32'h0040_0004)}) begin
            errors++; $display("FAIL sim_idone got=%b/%h exp=1/%h", if_ready, if_rdata, dflt(32'h0040_0004));
        end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_starvation();
        for (int r = 0; r < 2; r++) begin
            int nd;
            int guard;
            bit got_i;
            nd = 0; guard = 0; got_i = 1'b0;
            if_req = 1'b1; if_addr = 32'h0040_0100 + 32'(r * 4);
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
            while (!got_i && guard < 100) begin
                @(negedge clk);
                guard++;
                if (d_ready) begin
                    checks++;
                    if (d_rdata !== dflt(d_addr)) begin
                        errors++; $display("FAIL starve_drdata got=%h exp=%h", d_rdata, dflt(d_addr));
                    end
                    nd++;
                    d_addr = 32'h200 + 32'(nd * 4);
                end
                if (if_ready) begin
                    got_i = 1'b1;
                    checks++;
                    if (if_rdata !== dflt(if_addr)) begin
                        errors++; $display("FAIL starve_irdata got=%h exp=%h", if_rdata, dflt(if_addr));
                    end
                    if_req = 1'b0; d_req = 1'b0;
                end
            end
            checks++;
            if (!got_i || nd != STARVE) begin
                errors++; $display("FAIL starve_round%0d data_grants=%0d fetch_done=%0d exp=%0d/1", r, nd, got_i, STARVE);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ack_at_limit();
        int mc;
        int rc;
        mc = 0; rc = -1;
        resp_en = 1'b1; ack_delay = MAXWAIT;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        for (int c = 1; c <= 40 && rc < 0; c++) begin
            @(negedge clk);
            if (m_req) mc++;
            if (d_ready) begin rc = c; d_req = 1'b0; end
        end
        checks++;
        if (mc != MAXWAIT + 1 || rc != MAXWAIT + 2) begin
            errors++; $display("FAIL limit_timing mreq=%0d ready_cycle=%0d exp=%0d/%0d", mc, rc, MAXWAIT + 1, MAXWAIT + 2);
        end
        checks++;
        if ({err, d_rdata} !== {1'b0, dflt(32'h300)}) begin
            errors++; $display("FAIL limit_data got=%b/%h exp=0/%h", err, d_rdata, dflt(32'h300));
        end
        @(negedge clk);
        ack_delay = 0;
    endtask

    task automatic test_watchdog();
        int mc;
        int rc;
        mc = 0; rc = -1;
        resp_en = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h304;
        for (int c = 1; c <= 40 && rc < 0; c++) begin
            @(negedge clk);
            if (m_req) mc++;
            if (d_ready) begin rc = c; d_req = 1'b0; end
        end
        checks++;
        if (mc != MAXWAIT + 1 || rc != MAXWAIT + 2) begin
            errors++; $display("FAIL wd_timing mreq=%0d ready_cycle=%0d exp=%0d/%0d", mc, rc, MAXWAIT + 1, MAXWAIT + 2);
        end
        checks++;
        if ({err, d_rdata} !== {1'b1, 32'd0}) begin
            errors++; $display("FAIL wd_result got=%b/%h exp=1/00000000", err, d_rdata);
        end
        @(negedge clk);
        resp_en = 1'b1; ack_delay = 0;
        if_req = 1'b1; if_addr = 32'h0040_0300;
        repeat (2) @(negedge clk);
        checks++;
        if ({if_ready, if_rdata, err} !== {1'b1, dflt(32'h0040_0300), 1'b1}) begin
            errors++; $display("FAIL wd_sticky got=%b/%h/%b exp=1/%h/1", if_ready, if_rdata, err, dflt(32'h0040_0300));
        end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        resp_en = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'h1234;
        repeat (2) @(negedge clk);
        checks++;
        if ({m_req, m_addr} !== {1'b1, 32'h500}) begin
            errors++; $display("FAIL rst_pre got=%b/%h exp=1/00000500", m_req, m_addr);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({m_req, m_we, err, m_addr, m_wdata} !== 67'd0) begin
            errors++; $display("FAIL rst_async got=%b/%b/%b/%h/%h exp=0", m_req, m_we, err, m_addr, m_wdata);
        end
        d_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        man_ack = 1'b0; man_rdata = 32'd0;
        checks++;
        if ({m_req, if_ready, d_ready} !== 3'b000) begin
            errors++; $display("FAIL rst_late_ack got=%b exp=000", {m_req, if_ready, d_ready});
        end
        @(negedge clk);
        checks++;
        if ({if_rdata, d_rdata} !== 64'd0) begin
            errors++; $display("FAIL rst_rdata got=%h/%h exp=0", if_rdata, d_rdata);
        end
        resp_en = 1'b1; ack_delay = 0;
        if_req = 1'b1; if_addr = 32'h0040_0200;
        @(negedge clk);
        checks++;
        if ({m_req, m_we, m_addr} !== {1'b1, 1'b0, 32'h0040_0200}) begin
            errors++; $display("FAIL rst_next_grant got=%b/%b/%h exp=1/0/00400200", m_req, m_we, m_addr);
        end
        @(negedge clk);
        checks++;
        if ({if_ready, if_rdata, err} !== {1'b1, dflt(32'h0040_0200), 1'b0}) begin
            errors++; $display("FAIL rst_next_done got=%b/%h/%b exp=1/%h/0", if_ready, if_rdata, err, dflt(32'h0040_0200));
        end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_variable_latency();
        int mc;
        int rdy;
        int rc;
        int addr_bad;
        int stall_bad;
        mc = 0; rdy = 0; rc = -1; addr_bad = 0; stall_bad = 0;
        resp_en = 1'b1; ack_delay = 5;
        if_req = 1'b1; if_addr = 32'h0040_0008;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (m_req) begin
                mc++;
                if (m_addr !== 32'h0040_0008) addr_bad++;
            end
            if (if_stall !== (c <= 6)) stall_bad++;
            if (if_ready) begin
                rdy++; rc = c;
                checks++;
                if (if_rdata !== dflt(32'h0040_0008)) begin
                    errors++; $display("FAIL vl_rdata got=%h exp=%h", if_rdata, dflt(32'h0040_0008));
                end
                if_req = 1'b0;
            end
        end
        checks++;
        if (mc != 6 || rdy != 1 || rc != 7) begin
            errors++; $display("FAIL vl_timing mreq=%0d pulses=%0d ready_cycle=%0d exp=6/1/7", mc, rdy, rc);
        end
        checks++;
        if (addr_bad != 0 || stall_bad != 0) begin
            errors++; $display("FAIL vl_stable addr_errs=%0d stall_errs=%0d exp=0/0", addr_bad, stall_bad);
        end
        ack_delay = 0;
    endtask

    task automatic test_random();
        mem_arr.delete();
        ref_mem.delete();
        resp_en = 1'b1; rnd_lat = 1'b1;
        f_done = 1'b0; d_done = 1'b0;
        fork
            begin : fetch_req
                for (int i = 0; i < NRND; i++) begin
                    int gap;
                    int g;
                    bit ok;
                    logic [31:0] a;
                    gap = int'($urandom_range(0, 2)); g = 0; ok = 1'b0;
                    if (gap > 0) begin if_req = 1'b0; repeat (gap) @(negedge clk); end
                    a = 32'h0040_0000 + 32'($urandom_range(0, 15) * 4);
                    if_addr = a; if_req = 1'b1;
                    while (!ok && g < 200) begin @(negedge clk); g++; if (if_ready) ok = 1'b1; end
                    checks++;
                    if (!ok) begin
                        errors++; $display("FAIL rnd_if_timeout addr=%h waited=%0d exp=ready", a, g);
                    end else begin
                        $display("txn fetch addr=%h data=%h", a, if_rdata);
                        checks++;
                        if (if_rdata !== dflt(a)) begin
                            errors++; $display("FAIL rnd_if_rdata got=%h exp=%h", if_rdata, dflt(a));
                        end
                    end
                end
                if_req = 1'b0;
                f_done = 1'b1;
            end
            begin : data_req
                logic [31:0] last_rd;
                last_rd = 32'd0;
                for (int i = 0; i < NRND; i++) begin
                    int gap;
                    int g;
                    bit ok;
                    bit we;
                    logic [31:0] a;
                    logic [31:0] wd;
                    logic [31:0] exp_rd;
                    gap = int'($urandom_range(0, 2)); g = 0; ok = 1'b0;
                    if (gap > 0) begin d_req = 1'b0; repeat (gap) @(negedge clk); end
                    a  = 32'h1000_0000 + 32'($urandom_range(0, 7) * 4);
                    we = 1'($urandom_range(0, 1));
                    wd = $urandom;
                    exp_rd = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
                    if (we) ref_mem[a] = wd;
                    else last_rd = exp_rd;
                    d_addr = a; d_we = we; d_wdata = wd; d_req = 1'b1;
                    while (!ok && g < 200) begin @(negedge clk); g++; if (d_ready) ok = 1'b1; end
                    checks++;
                    if (!ok) begin
                        errors++; $display("FAIL rnd_d_timeout addr=%h waited=%0d exp=ready", a, g);
                    end else begin
                        $display("txn data %s addr=%h wdata=%h rdata=%h", we ? "store" : "load ", a, wd, d_rdata);
                        checks++;
                        if (d_rdata !== last_rd) begin
                            errors++; $display("FAIL rnd_d_rdata we=%0d got=%h exp=%h", we, d_rdata, last_rd);
                        end
                    end
                end
                d_req = 1'b0;
                d_done = 1'b1;
            end
            begin : arb_monitor
                bit idle_m;
                bit skip_next;
                int starve_m;
                int iter;
                bit s_if;
                bit s_d;
                bit s_we;
                logic [31:0] s_ia;
                logic [31:0] s_da;
                logic [31:0] s_wd;
                idle_m = 1'b1; skip_next = 1'b0; starve_m = 0; iter = 0;
                while (!(f_done && d_done) && iter < 20000) begin
                    iter++;
                    @(posedge clk);
                    s_if = if_req; s_d = d_req; s_we = d_we; s_ia = if_addr; s_da = d_addr; s_wd = d_wdata;
                    @(negedge clk);
                    if (idle_m) begin
                        if (s_d && (!s_if || starve_m < STARVE)) begin
                            checks++;
                            if ({m_req, m_we, m_addr} !== {1'b1, s_we, s_da} || (s_we && m_wdata !== s_wd)) begin
                                errors++;
                                $display("FAIL rnd_dgrant got=%b/%b/%h/%h exp=1/%b/%h/%h", m_req, m_we, m_addr, m_wdata, s_we, s_da, s_wd);
                            end
                            starve_m = s_if ? ((starve_m == 15) ? 15 : starve_m + 1) : 0;
                            idle_m = 1'b0;
                        end else if (s_if) begin
                            checks++;
                            if ({m_req, m_we, m_addr} !== {1'b1, 1'b0, s_ia}) begin
                                errors++; $display("FAIL rnd_igrant got=%b/%b/%h exp=1/0/%h", m_req, m_we, m_addr, s_ia);
                            end
                            starve_m = 0;
                            idle_m = 1'b0;
                        end else begin
                            checks++;
                            if (m_req !== 1'b0) begin errors++; $display("FAIL rnd_idle_mreq got=%b exp=0", m_req); end
                        end
                    end
                    if (skip_next) begin skip_next = 1'b0; idle_m = 1'b1; end
                    if (if_ready || d_ready) skip_next = 1'b1;
                end
            end
        join
        rnd_lat = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_ack_at_limit();
        test_watchdog();
        test_reset_mid_access();
        test_variable_latency();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
